mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter/controller that shares one 4:1 data mux among four requesters.

---
 rtl/mux4_rr_arbiter.sv | 115 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 data mux with bounded-hold preemption.
// Grant, select and pointer are registered; y is a combinational lane pick.
module mux4_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] d,
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic               busy,
  output logic [WIDTH-1:0]   y
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_TOP =
    (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [3:0]      others;
  logic            own_req;
  logic            do_grant;
  logic [3:0]      cand;
  logic [1:0]      win;

  // First set bit of m searching p, p+1, ... with 2-bit wrap.
  function automatic logic [1:0] pick(
    input logic [3:0] m,
    input logic [1:0] p
  );
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (m[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    others   = req & ~gnt_q;
    own_req  = |(req & gnt_q);
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    do_grant = 1'b0;
    cand     = req;
    unique case (state_q)
      IDLE: begin
        if (|req) do_grant = 1'b1;
      end
      GRANT: begin
        if (!own_req) begin
          if (|others) begin
            do_grant = 1'b1;
            cand     = others;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (MAX_HOLD != 0 && hold_q == HOLD_TOP
                     && |others) begin
          do_grant = 1'b1;
          cand     = others;
        end else if (hold_q != HOLD_TOP) begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
    win = pick(cand, ptr_q);
    if (do_grant) begin
      state_d = GRANT;
      gnt_d   = 4'b0001 << win;
      sel_d   = win;
      ptr_d   = win + 2'd1;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = |gnt_q;
  assign y    = busy ? d[sel_q*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic
// against an owner/pointer model, on MAX_HOLD=4 and MAX_HOLD=0 instances.
module tb_mux4_rr_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [4*W-1:0] d = '0;

  logic [3:0]   gnt4, gnt0;
  logic [1:0]   sel4, sel0;
  logic         busy4, busy0;
  logic [W-1:0] y4, y0;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt4), .sel(sel4), .busy(busy4), .y(y4)
  );

  mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt0), .sel(sel0), .busy(busy0), .y(y0)
  );

  typedef struct {
    int owner;
    int ptr;
    int held;
    int lsel;
  } mdl_t;

  mdl_t m4, m0;

  function automatic int first_from(logic [3:0] m, int p);
    for (int k = 0; k < 4; k++)
      if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // One clock edge of the arbitration rules, as cycles-held counts.
  function automatic mdl_t mstep(mdl_t s, logic [3:0] r, int mh);
    mdl_t n;
    logic [3:0] oth;
    int w;
    n = s;
    oth = r;
    w = -1;
    if (s.owner >= 0) oth[s.owner] = 1'b0;
    if (s.owner < 0) begin
      if (r != 0) w = first_from(r, s.ptr);
    end else if (!r[s.owner]) begin
      if (oth != 0) w = first_from(oth, s.ptr);
      else n.owner = -1;
    end else if (mh > 0 && s.held >= mh && oth != 0) begin
      w = first_from(oth, s.ptr);
    end else begin
      n.held = s.held + 1;
    end
    if (w >= 0) begin
      n.owner = w;
      n.lsel = w;
      n.ptr = (w + 1) % 4;
      n.held = 1;
    end
    return n;
  endfunction

  function automatic logic [14:0] expv(mdl_t s, logic [4*W-1:0] dd);
    logic [3:0] g;
    logic [W-1:0] yy;
    g = '0;
    yy = '0;
    if (s.owner >= 0) begin
      g[s.owner] = 1'b1;
      yy = dd[s.owner*W +: W];
    end
    return {g, 2'(s.lsel), s.owner >= 0, yy};
  endfunction

  function automatic mdl_t mreset();
    mdl_t s;
    s.owner = -1;
    s.ptr = 0;
    s.held = 0;
    s.lsel = 0;
    return s;
  endfunction

  task automatic step();
    m4 = mstep(m4, req, 4);
    m0 = mstep(m0, req, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m4 = mreset();
    m0 = mreset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    d = $urandom;
    rst_n = 1'b0;
    m4 = mreset();
    m0 = mreset();
    #1;
    n_run++;
    if ({gnt4, sel4, busy4, y4} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outs got=%h want=0",
               {gnt4, sel4, busy4, y4});
    end
    n_run++;
    if ({gnt0, sel0, busy0, y0} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outs0 got=%h want=0",
               {gnt0, sel0, busy0, y0});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    n_run++;
    if (gnt4 !== 4'b0001 || gnt0 !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first got=%b/%b want=0001", gnt4, gnt0);
    end
    req = '0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    d = $urandom;
    req = 4'b0100;
    step();
    n_run++;
    if (gnt4 !== 4'b0100 || sel4 !== 2'd2
        || y4 !== d[2*W +: W] || busy4 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant got=%b sel=%0d y=%h want=0100 2 %h",
               gnt4, sel4, y4, d[2*W +: W]);
    end
    req = '0;
    step();
    n_run++;
    if (gnt4 !== 4'b0 || busy4 !== 1'b0 || sel4 !== 2'd2
        || y4 !== '0) begin
      n_fail++;
      $display("FAIL single_drop got=%b busy=%b sel=%0d y=%h want=0 0 2 0",
               gnt4, busy4, sel4, y4);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    step();
    for (int k = 0; k < 4; k++) begin
      exp = 4'b0001 << k;
      step();
      n_run++;
      if (gnt0 !== exp || gnt4 !== exp) begin
        n_fail++;
        $display("FAIL rr_hold%0d got=%b/%b want=%b", k, gnt0, gnt4, exp);
      end
      req[k] = 1'b0;
      step();
      req = 4'b1111;
      exp = 4'b0001 << ((k + 1) % 4);
      n_run++;
      if (gnt0 !== exp || busy0 !== 1'b1 || gnt4 !== exp) begin
        n_fail++;
        $display("FAIL rr_next%0d got=%b/%b busy=%b want=%b",
                 k, gnt0, gnt4, busy0, exp);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b0001;
    step();
    step();
    req = 4'b1001;
    for (int c = 2; c <= 4; c++) begin
      step();
      n_run++;
      if (gnt4 !== ((c == 4) ? 4'b1000 : 4'b0001)) begin
        n_fail++;
        $display("FAIL preempt_c%0d got=%b want=%b", c, gnt4,
                 (c == 4) ? 4'b1000 : 4'b0001);
      end
    end
    n_run++;
    if (gnt0 !== 4'b0001) begin
      n_fail++;
      $display("FAIL nohold_limit got=%b want=0001", gnt0);
    end
    req = 4'b0001;
    step();
    n_run++;
    if (gnt4 !== 4'b0001 || busy4 !== 1'b1) begin
      n_fail++;
      $display("FAIL preempt_return got=%b want=0001", gnt4);
    end
    req = '0;
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    step();
    req = '0;
    step();
    req = 4'b1001;
    step();
    n_run++;
    if (gnt4 !== 4'b1000 || gnt0 !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_first got=%b/%b want=1000", gnt4, gnt0);
    end
    req = 4'b0001;
    step();
    n_run++;
    if (gnt4 !== 4'b0001 || gnt0 !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_second got=%b/%b want=0001", gnt4, gnt0);
    end
    req = '0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010;
    step();
    step();
    #2;
    rst_n = 1'b0;
    m4 = mreset();
    m0 = mreset();
    #1;
    n_run++;
    if (gnt4 !== 4'b0 || busy4 !== 1'b0 || sel4 !== 2'd0
        || gnt0 !== 4'b0) begin
      n_fail++;
      $display("FAIL async_rst got=%b/%b busy=%b sel=%0d want=0",
               gnt4, gnt0, busy4, sel4);
    end
    #1;
    rst_n = 1'b1;
    step();
    n_run++;
    if (gnt4 !== 4'b0010 || gnt0 !== 4'b0010) begin
      n_fail++;
      $display("FAIL async_regrant got=%b/%b want=0010", gnt4, gnt0);
    end
    req = '0;
    step();
  endtask

  task automatic test_random();
    logic [14:0] e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
      d = $urandom;
      step();
      e = expv(m4, d);
      n_run++;
      if ({gnt4, sel4, busy4, y4} !== e) begin
        n_fail++;
        $display("FAIL rand4 c=%0d got=%h want=%h", c,
                 {gnt4, sel4, busy4, y4}, e);
      end
      e = expv(m0, d);
      n_run++;
      if ({gnt0, sel0, busy0, y0} !== e) begin
        n_fail++;
        $display("FAIL rand0 c=%0d got=%h want=%h", c,
                 {gnt0, sel0, busy0, y0}, e);
      end
    end
    req = '0;
    step();
  endtask

  initial begin
    m4 = mreset();
    m0 = mreset();
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_preempt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
